// File: rtl/instr_encoder_loader.sv
// Packs R/I/J field bundles into MIPS words and streams them into instruction memory.
// Optional ENC_STRICT_EN: reject opcode/format mismatches as illegal bundles.
module instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_imm26,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic              wrap,
    output logic [ADDR_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]   fifo [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fcnt;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept, push, pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        unique case (in_fmt)
            2'd0: enc_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
            2'd1: enc_word = {in_opcode, in_rs, in_rt, in_imm16};
            2'd2: enc_word = {in_opcode, in_imm26};
            default: enc_legal = 1'b0;
        endcase
`ifdef ENC_STRICT_EN
        if (in_fmt == 2'd0 && in_opcode != 6'd0)
            enc_legal = 1'b0;
        if ((in_fmt == 2'd1 || in_fmt == 2'd2) && in_opcode == 6'd0)
            enc_legal = 1'b0;
`endif
    end

    // Readiness depends only on registered state: no bypass when full.
    assign in_ready  = (fcnt < FULL) &&
                       (state == S_IDLE || state == S_RUN);
    assign accept    = in_valid & in_ready;
    assign push      = accept & enc_legal;
    assign mem_we    = (fcnt != '0);
    assign mem_wdata = mem_we ? fifo[rd_ptr] : 32'd0;
    assign pop       = mem_we & mem_ready;
    assign done      = (state == S_DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = in_last ? S_FLUSH : S_RUN;
            S_RUN:   if (accept && in_last) state_nx = S_FLUSH;
            S_FLUSH: if (fcnt == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            mem_addr <= BASE;
            count    <= '0;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fcnt <= fcnt + 1'b1;
            else if (pop && !push)
                fcnt <= fcnt - 1'b1;
            if (accept && !enc_legal)
                err <= 1'b1;
            if (pop) begin
                mem_addr <= mem_addr + 1'b1;
                count    <= count + 1'b1;
                if (mem_addr == '1)
                    wrap <= 1'b1;
            end
            // Next program starts again at the base address.
            if (state == S_DONE) begin
                mem_addr <= BASE;
                count    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4, ADDR_W=2).
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = '0;
    logic [5:0]  in_opcode = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm16 = '0;
    logic [25:0] in_imm26 = '0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        done;
    logic        err;
    logic        wrap;
    logic [1:0]  count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] maddr = '0;

    instr_encoder_loader #(
        .DEPTH(4),
        .ADDR_W(2),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_fmt(in_fmt),
        .in_opcode(in_opcode),
        .in_rs(in_rs),
        .in_rt(in_rt),
        .in_rd(in_rd),
        .in_shamt(in_shamt),
        .in_funct(in_funct),
        .in_imm16(in_imm16),
        .in_imm26(in_imm26),
        .in_last(in_last),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .done(done),
        .err(err),
        .wrap(wrap),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] i16,
                        input logic [25:0] i26, input logic last,
                        input logic legal, input logic [31:0] exp);
        int n = 0;
        in_valid  = 1'b1;
        in_fmt    = f;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_funct  = fn;
        in_imm16  = i16;
        in_imm26  = i26;
        in_last   = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (in_ready && legal) begin
            sbq.push_back('{a: maddr, d: exp});
            maddr = maddr + 1'b1;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] ecount,
                             input logic eerr, input logic ewrap);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'(ecount));
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        chk({tag, "_wrap"}, 32'(wrap), 32'(ewrap));
        chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_addr_reload"}, 32'(mem_addr), 32'd0);
        chk({tag, "_count_reload"}, 32'(count), 32'd0);
        maddr = '0;
        step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        sbq.delete();
        maddr = '0;
        rst_n = 1'b1;
    endtask

    logic        hold = 1'b0;
    logic [1:0]  haddr;
    logic [31:0] hdata;

    // Write monitor: pops the scoreboard and checks held outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                chk("hold_we", 32'(mem_we), 32'd1);
                chk("hold_addr", 32'(mem_addr), 32'(haddr));
                chk("hold_data", mem_wdata, hdata);
            end
            if (mem_we && mem_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", mem_wdata, e.d);
                end
            end
            hold  <= mem_we && !mem_ready;
            haddr <= mem_addr;
            hdata <= mem_wdata;
        end
    end

    initial begin
        #1;
        step();
        do_reset();
        @(negedge clk);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {29'd0, done, err, wrap}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        step();

        // add $3,$1,$2
        send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF,
             26'h3FFFFFF, 1'b1, 1'b1, 32'h0022_1820);
        wait_done("r1", 2'd1, 1'b0, 1'b0);

        // lw $8,4($0) then j 0x10
        send(2'd1, 6'h23, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004,
             26'h3FFFFFF, 1'b0, 1'b1, 32'h8C08_0004);
        send(2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF,
             26'h0000010, 1'b1, 1'b1, 32'h0800_0010);
        wait_done("ij", 2'd2, 1'b0, 1'b0);

        // Illegal bundle mid-stream leaves no address gap
        send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0,
             26'h0, 1'b0, 1'b1, 32'h0022_1820);
        send(2'd3, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234,
             26'h1234, 1'b0, 1'b0, 32'h0);
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
             26'h0000010, 1'b1, 1'b1, 32'h0800_0010);
        wait_done("illegal", 2'd2, 1'b1, 1'b0);

        do_reset();
`ifdef ENC_STRICT_EN
        send(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0,
             26'h0, 1'b1, 1'b0, 32'h0);
        wait_done("strict", 2'd0, 1'b1, 1'b0);
`else
        send(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0,
             26'h0, 1'b1, 1'b1, 32'h2022_1820);
        wait_done("strict", 2'd1, 1'b0, 1'b0);
`endif

        // Backpressure plus address wrap (ADDR_W=2): addi $1,$0,k
        do_reset();
        mem_ready = 1'b0;
        send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001,
             26'h0, 1'b0, 1'b1, 32'h2001_0001);
        send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0002,
             26'h0, 1'b0, 1'b1, 32'h2001_0002);
        send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0003,
             26'h0, 1'b0, 1'b1, 32'h2001_0003);
        send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0004,
             26'h0, 1'b0, 1'b1, 32'h2001_0004);
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_head_we", 32'(mem_we), 32'd1);
        chk("bp_head_addr", 32'(mem_addr), 32'd0);
        chk("bp_head_data", mem_wdata, 32'h2001_0001);
        chk("bp_no_wrap", 32'(wrap), 32'd0);
        step();
        repeat (10) step();
        mem_ready = 1'b1;
        send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0005,
             26'h0, 1'b1, 1'b1, 32'h2001_0005);
        wait_done("wrap", 2'd1, 1'b0, 1'b1);

        // Reset with words buffered discards them
        mem_ready = 1'b0;
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
             26'h0000001, 1'b0, 1'b1, 32'h0800_0001);
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
             26'h0000002, 1'b0, 1'b1, 32'h0800_0002);
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
             26'h0000003, 1'b0, 1'b1, 32'h0800_0003);
        do_reset();
        @(negedge clk);
        chk("mrst_we", 32'(mem_we), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_addr", 32'(mem_addr), 32'd0);
        chk("mrst_flags", {29'd0, done, err, wrap}, 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        step();
        mem_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("final_we", 32'(mem_we), 32'd0);
        chk("final_sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
